// File: rtl/instr_encoder_loader_if.sv
// rtl/instr_encoder_loader_if.sv - host instruction stream and imem write port bundle
interface instr_encoder_loader_if #(
   parameter int ADDR_W = 6
);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_mnem;
   logic [4:0]        in_rs;
   logic [4:0]        in_rt;
   logic [4:0]        in_rd;
   logic [15:0]       in_imm;
   logic [25:0]       in_target;
   logic              in_last;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      output in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs symbolic instructions into MIPS words and loads imem
module instr_encoder_loader #(
   parameter int ADDR_W    = 6,
   parameter int DEPTH     = 64,
   parameter int BASE_ADDR = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   instr_encoder_loader_if.slave bus,
   output logic [ADDR_W:0]      wr_count,
   output logic                 busy,
   output logic                 done,
   output logic                 full,
   output logic                 err_invalid
);
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;

   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);

   state_t            state;
   logic              closing;
   logic [ADDR_W-1:0] next_addr;
   logic              accept;
   logic              mnem_ok;

   function automatic logic [31:0] encode(
      input logic [3:0]  mnem,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [4:0]  rd,
      input logic [15:0] imm,
      input logic [25:0] target
   );
      case (mnem)
         4'd0:    encode = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
         4'd1:    encode = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
         4'd2:    encode = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
         4'd3:    encode = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
         4'd4:    encode = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
         4'd5:    encode = {6'b100011, rs, rt, imm};
         4'd6:    encode = {6'b101011, rs, rt, imm};
         4'd7:    encode = {6'b000100, rs, rt, imm};
         4'd8:    encode = {6'b001000, rs, rt, imm};
         4'd9:    encode = {6'b001100, rs, rt, imm};
         4'd10:   encode = {6'b001101, rs, rt, imm};
         4'd11:   encode = {6'b001010, rs, rt, imm};
         4'd12:   encode = {6'b000010, target};
         default: encode = 32'd0;
      endcase
   endfunction

   // closing drops in_ready for the write cycle of a last/filling word so nothing is lost
   assign bus.in_ready = (state == LOAD) && !closing;
   assign busy         = (state == LOAD);
   assign accept       = bus.in_valid && bus.in_ready;
   assign mnem_ok      = (bus.in_mnem <= 4'd12);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         closing        <= 1'b0;
         next_addr      <= BASE;
         wr_count       <= '0;
         done           <= 1'b0;
         full           <= 1'b0;
         err_invalid    <= 1'b0;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= '0;
         bus.imem_wdata <= '0;
      end else begin
         bus.imem_we <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= LOAD;
                  closing     <= 1'b0;
                  next_addr   <= BASE;
                  wr_count    <= '0;
                  done        <= 1'b0;
                  full        <= 1'b0;
                  err_invalid <= 1'b0;
               end
            end
            LOAD: begin
               if (closing) begin
                  state   <= DONE;
                  closing <= 1'b0;
                  done    <= 1'b1;
                  full    <= (wr_count == DEPTH_CNT);
               end else if (accept) begin
                  if (mnem_ok) begin
                     bus.imem_we    <= 1'b1;
                     bus.imem_addr  <= next_addr;
                     bus.imem_wdata <= encode(bus.in_mnem, bus.in_rs, bus.in_rt, bus.in_rd,
                                              bus.in_imm, bus.in_target);
                     next_addr      <= next_addr + 1'b1;
                     wr_count       <= wr_count + 1'b1;
                     closing        <= bus.in_last || (wr_count + 1'b1 == DEPTH_CNT);
                  end else begin
                     err_invalid <= 1'b1;
                     closing     <= bus.in_last;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - random and directed checks of two loader configurations against a session model
module tb_instr_encoder_loader;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, in_valid, in_last;
   logic [3:0]  in_mnem;
   logic [4:0]  in_rs, in_rt, in_rd;
   logic [15:0] in_imm;
   logic [25:0] in_target;

   instr_encoder_loader_if #(.ADDR_W(6)) bus0 ();
   instr_encoder_loader_if #(.ADDR_W(6)) bus1 ();

   assign bus0.in_valid = in_valid;   assign bus1.in_valid = in_valid;
   assign bus0.in_mnem = in_mnem;     assign bus1.in_mnem = in_mnem;
   assign bus0.in_rs = in_rs;         assign bus1.in_rs = in_rs;
   assign bus0.in_rt = in_rt;         assign bus1.in_rt = in_rt;
   assign bus0.in_rd = in_rd;         assign bus1.in_rd = in_rd;
   assign bus0.in_imm = in_imm;       assign bus1.in_imm = in_imm;
   assign bus0.in_target = in_target; assign bus1.in_target = in_target;
   assign bus0.in_last = in_last;     assign bus1.in_last = in_last;

   logic [1:0]       rdy, we, busy_o, done_o, full_o, err_o;
   logic [1:0][5:0]  addr;
   logic [1:0][31:0] wdata;
   logic [1:0][6:0]  wc;

   assign rdy[0] = bus0.in_ready;     assign rdy[1] = bus1.in_ready;
   assign we[0] = bus0.imem_we;       assign we[1] = bus1.imem_we;
   assign addr[0] = bus0.imem_addr;   assign addr[1] = bus1.imem_addr;
   assign wdata[0] = bus0.imem_wdata; assign wdata[1] = bus1.imem_wdata;

   instr_encoder_loader u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .bus(bus0), .wr_count(wc[0]),
      .busy(busy_o[0]), .done(done_o[0]), .full(full_o[0]), .err_invalid(err_o[0])
   );

   instr_encoder_loader #(.ADDR_W(6), .DEPTH(4), .BASE_ADDR(62)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .bus(bus1), .wr_count(wc[1]),
      .busy(busy_o[1]), .done(done_o[1]), .full(full_o[1]), .err_invalid(err_o[1])
   );

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // session model: one entry per instance, advanced once per rising edge
   int          depth_p [2] = '{64, 4};
   int          base_p  [2] = '{0, 62};
   logic [31:0] op_tab [13] = '{0, 0, 0, 0, 0, 35, 43, 4, 8, 12, 13, 10, 2};
   logic [31:0] fn_tab [5]  = '{32, 34, 36, 37, 42};
   bit          m_open [2], m_closing [2], m_done [2], m_full [2], m_err [2], m_wr [2];
   int          m_count [2], m_next [2], m_addr [2];
   logic [31:0] m_data [2];

   function automatic logic [31:0] ref_enc(input logic [3:0] m, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
      logic [31:0] w;
      if (m < 5)
         w = ({27'd0, rs} << 21) | ({27'd0, rt} << 16) | ({27'd0, rd} << 11) | fn_tab[m];
      else if (m < 12)
         w = (op_tab[m] << 26) | ({27'd0, rs} << 21) | ({27'd0, rt} << 16) | {16'd0, imm};
      else
         w = (op_tab[12] << 26) | {6'd0, tgt};
      return w;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_open[i] = 0; m_closing[i] = 0; m_done[i] = 0; m_full[i] = 0; m_err[i] = 0;
            m_wr[i] = 0; m_count[i] = 0; m_next[i] = base_p[i];
         end else begin
            m_wr[i] = 0;
            if (!m_open[i]) begin
               if (start) begin
                  m_open[i] = 1; m_closing[i] = 0; m_done[i] = 0; m_full[i] = 0;
                  m_err[i] = 0; m_count[i] = 0; m_next[i] = base_p[i];
               end
            end else if (m_closing[i]) begin
               m_open[i] = 0; m_closing[i] = 0; m_done[i] = 1;
               m_full[i] = (m_count[i] == depth_p[i]);
            end else if (in_valid) begin
               if (in_mnem <= 12) begin
                  m_wr[i] = 1;
                  m_addr[i] = m_next[i];
                  m_data[i] = ref_enc(in_mnem, in_rs, in_rt, in_rd, in_imm, in_target);
                  m_next[i] = (m_next[i] + 1) % 64;
                  m_count[i]++;
                  m_closing[i] = in_last || (m_count[i] == depth_p[i]);
               end else begin
                  m_err[i] = 1;
                  m_closing[i] = in_last;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d in_ready", i), 32'(rdy[i]), 32'(m_open[i] && !m_closing[i]));
            chk($sformatf("u%0d imem_we", i), 32'(we[i]), 32'(m_wr[i]));
            if (m_wr[i]) begin
               chk($sformatf("u%0d imem_addr", i), 32'(addr[i]), 32'(m_addr[i]));
               chk($sformatf("u%0d imem_wdata", i), wdata[i], m_data[i]);
            end
            chk($sformatf("u%0d wr_count", i), 32'(wc[i]), 32'(m_count[i]));
            chk($sformatf("u%0d busy", i), 32'(busy_o[i]), 32'(m_open[i]));
            chk($sformatf("u%0d done", i), 32'(done_o[i]), 32'(m_done[i]));
            chk($sformatf("u%0d full", i), 32'(full_o[i]), 32'(m_full[i]));
            chk($sformatf("u%0d err_invalid", i), 32'(err_o[i]), 32'(m_err[i]));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic word(input int m, input int rs, input int rt, input int rd,
                       input int imm, input int tgt, input bit last);
      in_mnem = 4'(m); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
      in_imm = 16'(imm); in_target = 26'(tgt); in_last = last; in_valid = 1'b1;
   endtask

   task automatic new_session();
      rst_n = 1'b0; cyc(); rst_n = 1'b1;
      start = 1'b1; cyc(); start = 1'b0;
   endtask

   int n1;
   int a1 [4];

   initial begin
      rst_n = 0; start = 0; in_valid = 0; in_last = 0;
      in_mnem = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_imm = 0; in_target = 0;
      cyc(); cyc();
      cmp_en = 1'b1;
      chk("reset in_ready", 32'(rdy[0]), 0);
      chk("reset imem_we", 32'(we[0]), 0);
      chk("reset busy", 32'(busy_o[0]), 0);
      chk("reset wr_count", 32'(wc[0]), 0);
      chk("reset done", 32'(done_o[0]), 0);

      rst_n = 1; start = 1; cyc(); start = 0;
      word(8, 0, 8, 0, 5, 0, 0); cyc(); in_valid = 0;
      chk("addi we", 32'(we[0]), 1);
      chk("addi addr", 32'(addr[0]), 0);
      chk("addi wdata", wdata[0], 32'h20080005);
      chk("addi wr_count", 32'(wc[0]), 1);
      chk("addi base62 addr", 32'(addr[1]), 62);

      new_session();
      word(0, 8, 9, 10, 0, 0, 0); cyc();
      chk("add addr", 32'(addr[0]), 0);  chk("add wdata", wdata[0], 32'h01095020);
      chk("b62 addr0", 32'(addr[1]), 62);
      word(5, 29, 8, 0, 4, 0, 0); cyc();
      chk("lw addr", 32'(addr[0]), 1);   chk("lw wdata", wdata[0], 32'h8FA80004);
      chk("b62 addr1", 32'(addr[1]), 63);
      word(7, 8, 9, 0, 16'hFFFF, 0, 0); cyc();
      chk("beq addr", 32'(addr[0]), 2);  chk("beq wdata", wdata[0], 32'h1109FFFF);
      chk("b62 wrap", 32'(addr[1]), 0);
      word(12, 0, 0, 0, 0, 26'h10, 1); cyc(); in_valid = 0; in_last = 0;
      chk("j addr", 32'(addr[0]), 3);    chk("j wdata", wdata[0], 32'h08000010);
      cyc();
      chk("last done", 32'(done_o[0]), 1); chk("last busy", 32'(busy_o[0]), 0);
      chk("last in_ready", 32'(rdy[0]), 0); chk("last full", 32'(full_o[0]), 0);
      chk("last+fill done", 32'(done_o[1]), 1); chk("last+fill full", 32'(full_o[1]), 1);

      new_session();
      word(0, 1, 1, 1, 0, 0, 0); cyc();
      word(14, 1, 2, 3, 0, 0, 0); cyc();
      chk("inv no we", 32'(we[0]), 0); chk("inv err", 32'(err_o[0]), 1);
      chk("inv wr_count", 32'(wc[0]), 1);
      word(1, 1, 2, 3, 0, 0, 0); cyc();
      chk("sub addr", 32'(addr[0]), 1); chk("sub wdata", wdata[0], 32'h00221822);
      word(15, 0, 0, 0, 0, 0, 1); cyc(); in_valid = 0; in_last = 0;
      cyc();
      chk("inv last done", 32'(done_o[0]), 1); chk("err sticky", 32'(err_o[0]), 1);
      start = 1; cyc(); start = 0;
      chk("err cleared", 32'(err_o[0]), 0); chk("restart busy", 32'(busy_o[0]), 1);

      n1 = 0;
      for (int k = 0; k < 6; k++) begin
         word(8, k, k, 0, k, 0, 0); cyc();
         if (we[1]) begin
            if (n1 < 4) a1[n1] = int'(addr[1]);
            n1++;
         end
         if (k == 3) chk("fill in_ready", 32'(rdy[1]), 0);
      end
      in_valid = 0;
      chk("fill writes", n1, 4);
      chk("fill a0", a1[0], 62); chk("fill a1", a1[1], 63);
      chk("fill a2", a1[2], 0);  chk("fill a3", a1[3], 1);
      chk("fill full", 32'(full_o[1]), 1); chk("fill done", 32'(done_o[1]), 1);

      new_session();
      word(8, 0, 8, 0, 5, 0, 0); cyc(); in_valid = 0;
      rst_n = 0; cyc();
      chk("rst we", 32'(we[0]), 0); chk("rst busy", 32'(busy_o[0]), 0);
      chk("rst wdata", wdata[0], 0);
      rst_n = 1; start = 1; cyc(); start = 0;
      word(9, 1, 2, 0, 7, 0, 0); cyc(); in_valid = 0;
      start = 1; cyc(); start = 0;
      chk("start in load wr_count", 32'(wc[0]), 1);

      for (int ph = 0; ph < 2; ph++) begin
         repeat (ph == 0 ? 3000 : 400) begin
            rst_n = (ph == 1) || ($urandom_range(0, 199) != 0);
            start = ($urandom_range(0, 19) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            in_mnem = 4'($urandom_range(0, 15));
            in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
            in_imm = 16'($urandom); in_target = 26'($urandom);
            in_last = (ph == 0) && ($urandom_range(0, 9) == 0);
            cyc();
         end
      end
      in_valid = 0; start = 0;
      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Streaming instruction encoder and loader. It is the inverse of the main controller decoder: it takes symbolic instruction fields (mnemonic, registers, immediate, jump target) over a valid/ready handshake. It packs each instruction into a 32-bit MIPS R/I/J word using the same opcode/funct map the controller decodes, then writes the words sequentially into instruction memory. It sits between the test/boot host and the imem write port, and preloads programs before the core is released.

Parameters:
ADDR_W, 6, imem word-address width
DEPTH, 64, maximum words written per load session (must be ≤ 2^ADDR_W)
BASE_ADDR, 0, first imem word address of a session

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; opens a load session
in_valid  in  1  host presents an instruction
in_ready  out  1  block accepts an instruction this cycle
in_mnem  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 ADDI, 9 ANDI, 10 ORI, 11 SLTI, 12 J, 13-15 invalid
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field (R-type only)
in_imm  in  16  immediate (I-type only)
in_target  in  26  jump target (J only)
in_last  in  1  marks final instruction of the session
imem_we  out  1  imem write strobe
imem_addr  out  ADDR_W  imem word address
imem_wdata  out  32  encoded instruction
wr_count  out  ADDR_W+1  words written this session
busy  out  1  session open (LOAD state)
done  out  1  session closed normally or by full
full  out  1  DEPTH words written
err_invalid  out  1  sticky; an invalid mnemonic was received

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; all outputs 0; next address = BASE_ADDR; any pending write dropped. Reset mid-session aborts the session with no further imem_we.
- FSM states:
  - IDLE: in_ready=0. start=1 → LOAD; clears wr_count, done, full and err_invalid; address = BASE_ADDR.
  - LOAD: busy=1; in_ready = !full_pending.
  - DONE: done=1; in_ready=0. start → LOAD (new session, same clears).
- start is ignored while in LOAD.
- Handshake: a transfer happens when in_valid && in_ready at a rising edge. All in_* fields are sampled on that edge only.
- Latency: exactly 1 cycle. On the cycle after acceptance, imem_we=1 with imem_addr and imem_wdata; imem_we is 0 on all other cycles. Back-to-back acceptance gives back-to-back writes at consecutive addresses.
- Encoding:
  - R-type (0-4): {000000, rs, rt, rd, 00000, funct}. funct: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - I-type (5-11): {op, rs, rt, imm}. op: LW 100011, SW 101011, BEQ 000100, ADDI 001000, ANDI 001100, ORI 001101, SLTI 001010. imm is passed raw; no sign manipulation.
  - J (12): {000010, target}.
  - Unused fields of each format are ignored.
- Invalid mnemonic (13-15):
  - The transfer is accepted, but no imem write occurs and the address and wr_count do not advance.
  - err_invalid is set and stays set until the next start or reset.
  - in_last on an invalid word still ends the session.
- Address and count: after each write, address increments by 1 and wraps modulo 2^ADDR_W; wr_count increments by 1.
- Full: when the DEPTH-th valid word is accepted, in_ready drops the next cycle. That word is written, then full=1, done=1 and the FSM goes to DONE.
- in_last: after the accepted last word is written (or dropped, if invalid), the FSM goes to DONE with done=1.
- Last word that also fills DEPTH: done=1 and full=1 together.

Test Plan:
- Reset, then start, then ADDI rs=0 rt=8 imm=5 → next cycle imem_we=1, addr=0, wdata=0x20080005; wr_count=1.
- Back-to-back stream ADD rd=10 rs=8 rt=9, LW rt=8 rs=29 imm=4, BEQ rs=8 rt=9 imm=0xFFFF, J target=0x10 (last) → writes on consecutive cycles at addr 0..3 with 0x01095020, 0x8FA80004, 0x1109FFFF, 0x08000010; then done=1, busy=0, in_ready=0.
- in_mnem=14 mid-stream, followed by SUB → invalid word not written; SUB lands at the next address; err_invalid=1 until the next start.
- DEPTH=4: feed 5 valid words with no last → exactly 4 writes (addr 0-3); in_ready low after the 4th; full=1, done=1; 5th word held off.
- rst_n low the cycle after an acceptance → no imem_we that cycle, all outputs 0, state IDLE; start pulsed during LOAD has no effect on wr_count.
- BASE_ADDR=62, ADDR_W=6: 3 words → addresses 62, 63, 0.
